// File: rtl/fp_pkg.sv
// Shared definitions for the fixed-latency FP result path.
// FP_LATENCY is the single source for both the data delay line depth and the
// collector's tracking depth, so the two can never drift apart.
package fp_pkg;

  localparam int unsigned FP_DATA_W     = 33;  // flag bit + 32-bit float
  localparam int unsigned FP_LATENCY    = 12;  // FP core latency in cycles
  localparam int unsigned FP_FIFO_DEPTH = 16;  // >= FP_LATENCY + 2 for full rate

  // One buffered result: core output plus the packet-last marker it travelled with.
  typedef struct packed {
    logic [FP_DATA_W-1:0] data;
    logic                 last;
  } fp_entry_t;

endpackage

// File: rtl/fp_vld_dly.sv
// DELAY-stage {vld, last} shift register that shadows the FP core pipeline.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_vld, in_last   issue strobe and its packet-last flag (stage 0 input)
//   out_vld, out_last stage DELAY-1 output; out_vld marks the capture cycle
module fp_vld_dly
  import fp_pkg::*;
#(
  parameter int unsigned DELAY = FP_LATENCY
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_vld,
  input  logic in_last,
  output logic out_vld,
  output logic out_last
);

  logic [DELAY-1:0] vld_q;
  logic [DELAY-1:0] last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      last_q <= '0;
    end else begin
      vld_q[0]  <= in_vld;
      // Idle stages carry last=0 so a stale flag can never ride a later op.
      last_q[0] <= in_vld & in_last;
      for (int i = 1; i < int'(DELAY); i++) begin
        vld_q[i]  <= vld_q[i-1];
        last_q[i] <= last_q[i-1];
      end
    end
  end

  assign out_vld  = vld_q[DELAY-1];
  assign out_last = last_q[DELAY-1];

endmodule

// File: rtl/fp_result_collector.sv
// Receive end of the fixed-latency FP path. Tracks issued ops through a
// {vld, last} delay line, captures the core result exactly DELAY cycles after
// issue into a FIFO, and presents it on an AXI-Stream master. An outstanding
// counter (in-flight + stored) throttles issue so a capture never finds the
// FIFO full.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   issue_valid, issue_last    upstream launch request and packet-last flag
//   issue_ready                room exists for the eventual result
//   res_data                   FP core output, sampled only in the capture cycle
//   m_tvalid/m_tready/m_tdata/m_tlast  AXI-Stream master
// DATA_W must equal FP_DATA_W (FIFO entries use the shared fp_entry_t).
module fp_result_collector
  import fp_pkg::*;
#(
  parameter int unsigned DATA_W = FP_DATA_W,
  parameter int unsigned DELAY  = FP_LATENCY,
  parameter int unsigned DEPTH  = FP_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic              issue_last,
  output logic              issue_ready,
  input  logic [DATA_W-1:0] res_data,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  localparam logic [AW:0]   PtrOne = {{AW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] CntOne = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CntMax = CW'(DEPTH);

  logic          issue_fire;
  logic          capture;
  logic          cap_last;
  logic          pop;
  logic          full;
  logic          empty;
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;
  logic [CW-1:0] outstanding_q;
  fp_entry_t     mem_q [DEPTH];
  fp_entry_t     head;

  // Combinational from the registered counter; held low throughout reset.
  assign issue_ready = rst_n && (outstanding_q < CntMax);
  assign issue_fire  = issue_valid && issue_ready;

  fp_vld_dly #(
    .DELAY (DELAY)
  ) u_vld_dly (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (issue_fire),
    .in_last  (issue_last),
    .out_vld  (capture),
    .out_last (cap_last)
  );

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign m_tvalid = !empty;
  assign pop      = m_tvalid && m_tready;
  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  // Head slot is never rewritten while occupied, so data holds under stall.
  assign m_tdata  = empty ? '0 : DATA_W'(head.data);
  assign m_tlast  = !empty && head.last;

  // Storage needs no reset: contents are only visible through a non-empty head.
  always_ff @(posedge clk) begin
    if (capture) begin
      mem_q[wr_ptr_q[AW-1:0]] <= '{data: FP_DATA_W'(res_data), last: cap_last};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      outstanding_q <= '0;
    end else begin
      // Capture is unconditional; the credit counter guarantees space.
      if (capture) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)     rd_ptr_q <= rd_ptr_q + PtrOne;
      if (issue_fire && !pop) begin
        outstanding_q <= outstanding_q + CntOne;
      end else if (!issue_fire && pop) begin
        outstanding_q <= outstanding_q - CntOne;
      end
    end
  end

  overflow_a: assert property (@(posedge clk) disable iff (!rst_n) !(capture && full));
  underflow_a: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));
  credit_underflow_a: assert property (@(posedge clk) disable iff (!rst_n)
                                       !(pop && !issue_fire && outstanding_q == '0));

endmodule

// File: tb/tb_fp_result_collector.sv
// Directed bench for fp_result_collector. The bench plays the FP core: each
// fire schedules its result value onto res_data exactly DELAY cycles later
// (garbage is driven in every other cycle), and a scoreboard queue holds the
// expected {data, last} stream in issue order.
module tb_fp_result_collector;
  import fp_pkg::*;

  localparam int unsigned DW    = FP_DATA_W;
  localparam int unsigned DLY   = FP_LATENCY;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          issue_valid = 1'b0;
  logic          issue_last = 1'b0;
  logic          issue_ready;
  logic [DW-1:0] res_data = '0;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;

  always #5 clk = ~clk;

  fp_result_collector #(
    .DATA_W (DW),
    .DELAY  (DLY),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_last  (issue_last),
    .issue_ready (issue_ready),
    .res_data    (res_data),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tdata     (m_tdata),
    .m_tlast     (m_tlast)
  );

  int            n_tests = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            fire_cnt = 0;
  int            pop_cnt = 0;
  logic [DW-1:0] next_val = '0;
  logic [DW:0]   exp_q [$];
  logic [DW:0]   exp_e;
  logic [DW-1:0] res_at [int];
  logic          stall_q = 1'b0;
  logic [DW-1:0] stall_data = '0;
  logic          stall_last = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // FP core model: result appears only in its capture cycle.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    res_data = res_at.exists(cyc) ? res_at[cyc] : {1'b1, 32'hDEAD_BEEF};
  end

  // Monitor / scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_q) begin
        check("stall_valid", m_tvalid, 1);
        check("stall_data", m_tdata, stall_data);
        check("stall_last", m_tlast, stall_last);
      end
      if (!m_tvalid) check("empty_data", m_tdata, '0);
      if (issue_valid && issue_ready) begin
        res_at[cyc + int'(DLY)] = next_val;
        exp_q.push_back({next_val, issue_last});
        fire_cnt++;
      end
      if (m_tvalid && m_tready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          check("pop_on_empty_model", exp_q.size(), 1);
        end else begin
          exp_e = exp_q.pop_front();
          check("out_data", m_tdata, exp_e[DW:1]);
          check("out_last", m_tlast, exp_e[0]);
        end
      end
      stall_q    = m_tvalid && !m_tready;
      stall_data = m_tdata;
      stall_last = m_tlast;
    end else begin
      stall_q = 1'b0;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    issue_valid = 1'b0;
    issue_last  = 1'b0;
    m_tready    = 1'b1;
    while ((exp_q.size() != 0 || dut.outstanding_q != 0) && n < 500) begin
      tick();
      n++;
    end
    check(tag, dut.outstanding_q, 0);
    check({tag, "_queue"}, exp_q.size(), 0);
  endtask

  int t0;
  int base;
  int bp;
  int bf;
  int n;

  initial begin
    // Reset: ready must stay low even with issue_valid asserted.
    issue_valid = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_ready", issue_ready, 0);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tlast", m_tlast, 0);
    tick();
    tick();
    issue_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("idle_ready", issue_ready, 1);
    check("idle_outstanding", dut.outstanding_q, 0);

    // Single op: visible DELAY+1 cycles after the issue cycle.
    m_tready    = 1'b1;
    issue_valid = 1'b1;
    issue_last  = 1'b1;
    next_val    = 33'h0_3F80_0000;
    t0 = cyc;
    tick();
    issue_valid = 1'b0;
    issue_last  = 1'b0;
    do @(negedge clk); while (!m_tvalid && cyc < t0 + 40);
    check("single_latency", cyc - t0, 13);
    check("single_data", m_tdata, 33'h0_3F80_0000);
    check("single_last", m_tlast, 1);
    @(negedge clk);
    check("single_outstanding", dut.outstanding_q, 0);
    check("single_tvalid_after", m_tvalid, 0);

    // Backpressure fill: exactly DEPTH fires, then ready drops.
    tick();
    m_tready    = 1'b0;
    issue_valid = 1'b1;
    base = fire_cnt;
    bp   = pop_cnt;
    for (int i = 0; i < 40; i++) begin
      next_val   = DW'(fire_cnt - base);
      issue_last = ((fire_cnt - base) == 15);
      tick();
    end
    check("fill_fires", fire_cnt - base, 16);
    check("fill_ready", issue_ready, 0);
    check("fill_outstanding", dut.outstanding_q, 16);
    check("fill_tvalid", m_tvalid, 1);
    issue_valid = 1'b0;
    m_tready    = 1'b1;
    @(negedge clk);
    check("fill_ready_at_pop", issue_ready, 0);
    @(negedge clk);
    check("fill_ready_after_pop", issue_ready, 1);
    tick();
    drain("fill_drain");
    check("fill_pops", pop_cnt - bp, 16);

    // Streaming: ready must never drop with DEPTH >= DELAY+2.
    m_tready = 1'b1;
    base = fire_cnt;
    bp   = pop_cnt;
    for (int i = 0; i < 200; i++) begin
      issue_valid = 1'b1;
      issue_last  = ((i % 50) == 49);
      next_val    = DW'(32'h4000_0000 + i);
      @(negedge clk);
      check("stream_ready", issue_ready, 1);
      tick();
    end
    drain("stream_drain");
    check("stream_fires", fire_cnt - base, 200);
    check("stream_pops", pop_cnt - bp, 200);

    // Full with a single-cycle ready pulse: one pop, one refill.
    m_tready    = 1'b0;
    issue_valid = 1'b1;
    base = fire_cnt;
    for (int i = 0; i < 32; i++) begin
      next_val = DW'(32'h5000_0000 + fire_cnt - base);
      tick();
    end
    check("fs_outstanding_full", dut.outstanding_q, 16);
    check("fs_tvalid", m_tvalid, 1);
    bf = fire_cnt;
    bp = pop_cnt;
    next_val = 33'h0_5000_0010;
    m_tready = 1'b1;
    @(negedge clk);
    check("fs_ready_before", issue_ready, 0);
    tick();
    m_tready = 1'b0;
    @(negedge clk);
    check("fs_ready_after_pop", issue_ready, 1);
    tick();
    @(negedge clk);
    check("fs_ready_refull", issue_ready, 0);
    repeat (4) tick();
    check("fs_one_pop", pop_cnt - bp, 1);
    check("fs_one_fire", fire_cnt - bf, 1);
    check("fs_outstanding_hold", dut.outstanding_q, 16);
    drain("fs_drain");

    // Random backpressure at ~30% ready.
    base = fire_cnt;
    n = 0;
    while ((fire_cnt - base) < 1000 && n < 20000) begin
      issue_valid = 1'b1;
      issue_last  = ($urandom_range(0, 7) == 0);
      next_val    = {($urandom_range(0, 1) == 1), 32'($urandom())};
      m_tready    = ($urandom_range(0, 99) < 30);
      tick();
      n++;
    end
    issue_valid = 1'b0;
    check("rand_fires", fire_cnt - base, 1000);
    drain("rand_drain");

    // Reset mid-burst: 3 buffered, 5 in flight.
    m_tready    = 1'b0;
    issue_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      next_val   = DW'(32'h6000_0000 + i);
      issue_last = (i == 7);
      tick();
    end
    issue_valid = 1'b0;
    issue_last  = 1'b0;
    repeat (7) tick();
    check("pre_rst_outstanding", dut.outstanding_q, 8);
    check("pre_rst_tvalid", m_tvalid, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tvalid", m_tvalid, 0);
    check("rst_mid_outstanding", dut.outstanding_q, 0);
    check("rst_mid_ready", issue_ready, 0);
    check("rst_mid_tdata", m_tdata, 0);
    exp_q.delete();
    tick();
    tick();
    rst_n    = 1'b1;
    m_tready = 1'b1;
    bp = pop_cnt;
    repeat (10) tick();
    check("rst_no_stale_pops", pop_cnt - bp, 0);
    check("rst_no_stale_tvalid", m_tvalid, 0);

    // Recovery: a fresh op flows normally after reset.
    issue_valid = 1'b1;
    issue_last  = 1'b1;
    next_val    = 33'h1_7F80_0000;
    bp = pop_cnt;
    tick();
    drain("post_rst_drain");
    check("post_rst_pops", pop_cnt - bp, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_result_collector.md
Name: fp_result_collector

Overview:
- Receive end of the fixed-latency FP pipeline path. It issues operations into a non-stallable FP core of latency DELAY and tracks each issue with an internal valid/last delay line.
- Captures the core's result exactly DELAY cycles after issue and buffers it in a FIFO. Results are presented on an AXI-Stream master with backpressure.
- Credit logic throttles issue so that no result is ever dropped. Sits between the FP datapath (output of the data delay lines / FP IP) and the accelerator's AXI-Stream output DMA.

Parameters:
DATA_W, 33, result width (flag bit + 32-bit float)
DELAY, 12, FP core latency in cycles; must match the data delay line depth; >= 1
DEPTH, 16, FIFO entries; power of two; >= 2; full throughput requires DEPTH >= DELAY+2

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
issue_valid  in  1  upstream wants to launch one op into the FP core this cycle
issue_last  in  1  op is last of a packet; travels with the op
issue_ready  out  1  collector can accept the eventual result; issue fires when issue_valid && issue_ready
res_data  in  DATA_W  FP core output; sampled only in the capture cycle
m_tvalid  out  1  AXI-Stream valid
m_tready  in  1  AXI-Stream ready
m_tdata  out  DATA_W  AXI-Stream data
m_tlast  out  1  AXI-Stream last

Behaviour:
- Reset (rst_n low, asynchronous): vld/last delay line, FIFO pointers and outstanding counter all cleared.
  - m_tvalid=0, m_tdata=0, m_tlast=0.
  - issue_ready forced 0 while rst_n is low.
  - Reset mid-operation discards all in-flight and buffered results; no partial packet resumes.
- issue_fire = issue_valid && issue_ready.
- Tracking: a DELAY-stage shift register of {vld, last}. Stage 0 loads {issue_fire, issue_last} and is cleared when issue_fire=0.
  - capture = vld output of stage DELAY-1, i.e. asserted exactly DELAY cycles after the issue edge.
- Capture: when capture=1, {res_data, last} is written to the FIFO at wr_ptr. The capture is unconditional; credits guarantee space.
- No bypass: a result written at edge t is first visible on m_tvalid after edge t. Issue-to-m_tvalid latency is DELAY+1 cycles minimum.
- Output: m_tvalid = FIFO not empty. m_tdata/m_tlast come from the registered head entry.
  - pop = m_tvalid && m_tready. Head advances on pop.
  - m_tdata and m_tlast hold stable while m_tvalid && !m_tready (AXI rule).
  - m_tdata is 0 when the FIFO is empty.
- Credits: outstanding counter, width clog2(DEPTH+1), counts in-flight plus stored results.
  - Increments on issue_fire; decrements on pop; unchanged when both occur in the same cycle.
  - issue_ready = !reset && (outstanding < DEPTH), combinational from the registered counter.
- Boundaries:
  - outstanding==DEPTH: issue_ready=0. A pop in that cycle raises issue_ready the next cycle.
  - FIFO empty with capture and m_tready=1 in the same cycle: write only; pop occurs the next cycle.
  - FIFO full and capture: cannot happen. Assertion flags overflow and underflow in simulation.
  - Pointers are log2(DEPTH)+1 bits with natural wrap; full/empty are derived from the MSB compare.
- Ordering: strictly in order; results leave in issue order.

Decomposition:
- Shared package fp_pkg holds:
  - FP_DATA_W = 33
  - FP_LATENCY = 12
  - the typedef of the {data, last} FIFO entry.
  - FP_LATENCY is the single source for both the data delay line DELAY and this block's DELAY.
- One sub-module: fp_vld_dly, a DELAY-stage {vld, last} shift register with async active-low reset.
- The FIFO and credit counter stay inline.

Test Plan:
- Single op: issue_fire at cycle 0 with issue_last=1; res_data=33'h0_3F800000 driven at cycle 12 only -> m_tvalid rises at cycle 13, m_tdata=33'h0_3F800000, m_tlast=1; outstanding returns to 0 after the pop.
- Backpressure fill: m_tready=0, issue_valid=1 continuously -> exactly 16 fires, then issue_ready=0. Set m_tready=1 -> 16 results in order (res_data = issue index); issue_ready reasserts one cycle after the first pop.
- Streaming: m_tready=1, 200 back-to-back issues with DELAY=12, DEPTH=16 -> issue_ready never drops; 200 outputs; m_tlast on indices 49/99/149/199 matches issue_last.
- Full and simultaneous: outstanding=16 with m_tready pulsed for one cycle -> exactly one pop, exactly one new fire the following cycle, outstanding stays at 16.
- Random m_tready at 30% duty over 1000 ops -> scoreboard shows in-order match, no overflow assertion, m_tdata stable while stalled.
- Reset mid-burst: rst_n low for 2 cycles with 5 ops in flight and 3 buffered -> m_tvalid=0 immediately, outstanding=0. Stale res_data arriving at the old capture cycles is never emitted.
